// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: S1 sub-products, S2 partial sums, S3 final sum.
// Optional signed mode is enabled by defining VEDIC_MULT_SIGNED_EN (adds the in_signed port).
module vedic_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef VEDIC_MULT_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         occupancy
);

    localparam int H    = WIDTH / 2;
    localparam int LVLS = (H > 2) ? $clog2(H) : 1;

    // Bottom-up form of the Vedic recursion: level k holds every chunk-pair product of
    // chunk size 2^(k+1); the top level's four products are LL, HL, LH and HH.
    function automatic logic [4*WIDTH-1:0] vedic_subproducts(input logic [WIDTH-1:0] a,
                                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] pp [LVLS][WIDTH/2][WIDTH/2];
        logic [1:0]       a2, b2;
        logic             cr1, cr2, c1, t3;
        int               sz, n;
        for (int k = 0; k < LVLS; k++)
            for (int i = 0; i < WIDTH/2; i++)
                for (int j = 0; j < WIDTH/2; j++)
                    pp[k][i][j] = '0;
        for (int i = 0; i < WIDTH/2; i++) begin
            for (int j = 0; j < WIDTH/2; j++) begin
                a2  = a[2*i +: 2];
                b2  = b[2*j +: 2];
                cr1 = a2[1] & b2[0];
                cr2 = a2[0] & b2[1];
                c1  = cr1 & cr2;
                t3  = a2[1] & b2[1];
                pp[0][i][j][3:0] = {t3 & c1, t3 ^ c1, cr1 ^ cr2, a2[0] & b2[0]};
            end
        end
        for (int k = 1; k < LVLS; k++) begin
            sz = 2 << k;
            n  = WIDTH / sz;
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++)
                    pp[k][i][j] = pp[k-1][2*i][2*j]
                                + ((pp[k-1][2*i+1][2*j] + pp[k-1][2*i][2*j+1]) << (sz/2))
                                + (pp[k-1][2*i+1][2*j+1] << sz);
        end
        return {pp[LVLS-1][1][1], pp[LVLS-1][0][1], pp[LVLS-1][1][0], pp[LVLS-1][0][0]};
    endfunction

    // Handshake: each stage loads when empty or when its successor frees a slot.
    logic s1_valid, s2_valid, s3_valid;
    logic s1_en, s2_en, s3_en;

    assign s3_en     = ~s3_valid | out_ready;
    assign s2_en     = ~s2_valid | s3_en;
    assign s1_en     = ~s1_valid | s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s3_valid;
    assign occupancy = {1'b0, s1_valid} + {1'b0, s2_valid} + {1'b0, s3_valid};

    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] sp_ll, sp_hl, sp_lh, sp_hh;

`ifdef VEDIC_MULT_SIGNED_EN
    logic op_neg, s1_neg, s2_neg;
    // -2^(W-1) negates to itself, which reads correctly as the unsigned magnitude 2^(W-1).
    assign op_a   = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign op_b   = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    assign op_neg = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
`else
    assign op_a = in_a;
    assign op_b = in_b;
`endif

    assign {sp_hh, sp_lh, sp_hl, sp_ll} = vedic_subproducts(op_a, op_b);

    logic [WIDTH-1:0]   s1_ll, s1_hl, s1_lh, s1_hh;
    logic [TAG_W-1:0]   s1_tag, s2_tag;
    logic [H-1:0]       s2_p0;
    logic [2*H:0]       s2_x;
    logic [3*H-1:0]     s2_y;

    logic [2*H:0]       x_a, x_b, x_sum;
    logic [3*H-1:0]     y_a, y_b, y_sum, z_a, z_b, z_sum;
    logic               carry;
    logic [2*WIDTH-1:0] p_final;

    // Generate/propagate carry chains for X, Y and the final upper sum.
    always_comb begin
        x_a   = {1'b0, s1_hl};
        x_b   = {{(H+1){1'b0}}, s1_ll[2*H-1:H]};
        y_a   = {{H{1'b0}}, s1_lh};
        y_b   = {s1_hh, {H{1'b0}}};
        z_a   = s2_y;
        z_b   = {{(H-1){1'b0}}, s2_x};
        x_sum = '0;
        y_sum = '0;
        z_sum = '0;
        carry = 1'b0;
        for (int i = 0; i <= 2*H; i++) begin
            x_sum[i] = x_a[i] ^ x_b[i] ^ carry;
            carry    = (x_a[i] & x_b[i]) | ((x_a[i] ^ x_b[i]) & carry);
        end
        carry = 1'b0;
        for (int i = 0; i < 3*H; i++) begin
            y_sum[i] = y_a[i] ^ y_b[i] ^ carry;
            carry    = (y_a[i] & y_b[i]) | ((y_a[i] ^ y_b[i]) & carry);
        end
        // Carry out of the upper sum is discarded: the full product always fits in 2*WIDTH.
        carry = 1'b0;
        for (int i = 0; i < 3*H; i++) begin
            z_sum[i] = z_a[i] ^ z_b[i] ^ carry;
            carry    = (z_a[i] & z_b[i]) | ((z_a[i] ^ z_b[i]) & carry);
        end
    end

`ifdef VEDIC_MULT_SIGNED_EN
    assign p_final = s2_neg ? -{z_sum, s2_p0} : {z_sum, s2_p0};
`else
    assign p_final = {z_sum, s2_p0};
`endif

    // NOTE: only valid bits and the visible output are reset; stage data is qualified by
    // its valid bit, so resetting it would add reset fan-out for no functional benefit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            out_p    <= '0;
            out_tag  <= '0;
        end else begin
            if (s1_en) s1_valid <= in_valid;
            if (s2_en) s2_valid <= s1_valid;
            if (s3_en) s3_valid <= s2_valid;
            if (s3_en && s2_valid) begin
                out_p   <= p_final;
                out_tag <= s2_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            s1_ll  <= sp_ll;
            s1_hl  <= sp_hl;
            s1_lh  <= sp_lh;
            s1_hh  <= sp_hh;
            s1_tag <= in_tag;
`ifdef VEDIC_MULT_SIGNED_EN
            s1_neg <= op_neg;
`endif
        end
        if (s2_en && s1_valid) begin
            s2_p0  <= s1_ll[H-1:0];
            s2_x   <= x_sum;
            s2_y   <= y_sum;
            s2_tag <= s1_tag;
`ifdef VEDIC_MULT_SIGNED_EN
            s2_neg <= s1_neg;
`endif
        end
    end

endmodule
